acq_mem_ctrl: RTL

- Sequencer for the 4-entry x 2-bit acquisition buffer memory (write/read/inc/address interface, internal auto-increment write pointer, full flag).
- Aligns the buffer's write pointer, captures one burst of DEPTH samples, then streams the buffer back to the host over a valid/ready port.
- Sits between the sample front-end (which drives the memory data input directly) and the host readout logic.

---
 rtl/acq_pkg.sv | 19 +
 rtl/acq_inc_pulser.sv | 18 +
 rtl/acq_mem_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared sizes and sequencer states for the acquisition buffer controller
package acq_pkg;

    localparam int ACQ_ADDR_W = 2;
    localparam int ACQ_DATA_W = 2;
    localparam int ACQ_DEPTH  = 4;

    typedef enum logic [2:0] {
        ALIGN,
        IDLE,
        WAIT_S,
        WRITE,
        INC,
        RD_REQ,
        RD_WAIT,
        OUT
    } acq_state_t;

endpackage

// File: rtl/acq_inc_pulser.sv
// rtl/acq_inc_pulser.sv - registered single-cycle mem_inc pulses, always separated by a low cycle
module acq_inc_pulser (
    input  logic new_clk,
    input  logic reset,
    input  logic trig,
    output logic pulse
);

    // A request arriving while the pulse is high is dropped, so the memory's edge detector always sees a gap.
    always_ff @(posedge new_clk or posedge reset) begin
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= trig && !pulse;
        end
    end

endmodule

// File: rtl/acq_mem_ctrl.sv
// rtl/acq_mem_ctrl.sv - aligns the buffer pointer, captures one burst, streams it to the host
module acq_mem_ctrl
    import acq_pkg::*;
#(
    parameter int ADDR_W = ACQ_ADDR_W,
    parameter int DATA_W = ACQ_DATA_W,
    parameter int DEPTH  = ACQ_DEPTH
) (
    input  logic              new_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sample_valid,
    output logic              sample_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_inc,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_full,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    acq_state_t        state;
    acq_state_t        next_state;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] wcnt_nxt;
    logic [ADDR_W-1:0] rcnt;
    logic [ADDR_W-1:0] rcnt_nxt;
    logic              align_seen;
    logic              align_final;
    logic              inc_trig;

    always_comb begin
        next_state = state;
        wcnt_nxt   = wcnt;
        rcnt_nxt   = rcnt;
        unique case (state)
            ALIGN:   if (mem_inc && align_final) next_state = IDLE;
            IDLE: begin
                if (start) begin
                    wcnt_nxt   = '0;
                    next_state = WAIT_S;
                end
            end
            WAIT_S:  if (sample_valid) next_state = WRITE;
            WRITE:   next_state = INC;
            INC: begin
                if (wcnt == LAST) begin
                    rcnt_nxt   = '0;
                    next_state = RD_REQ;
                end else begin
                    wcnt_nxt   = wcnt + 1'b1;
                    next_state = WAIT_S;
                end
            end
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: next_state = OUT;
            OUT: begin
                if (rd_ready) begin
                    if (rcnt == LAST) begin
                        next_state = IDLE;
                    end else begin
                        rcnt_nxt   = rcnt + 1'b1;
                        next_state = RD_REQ;
                    end
                end
            end
            default: next_state = ALIGN;
        endcase
    end

    // ALIGN pulses on every low cycle; the final pulse is the one that follows the first full sighting.
    assign inc_trig = ((state == ALIGN) && !mem_inc) || (next_state == INC);

    acq_inc_pulser u_inc_pulser (
        .new_clk (new_clk),
        .reset   (reset),
        .trig    (inc_trig),
        .pulse   (mem_inc)
    );

    // Outputs are decoded from next_state and registered so they line up with the state they belong to.
    always_ff @(posedge new_clk or posedge reset) begin
        if (reset) begin
            state       <= ALIGN;
            wcnt        <= '0;
            rcnt        <= '0;
            align_seen  <= 1'b0;
            align_final <= 1'b0;
            sample_ack  <= 1'b0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= next_state;
            wcnt  <= wcnt_nxt;
            rcnt  <= rcnt_nxt;
            if ((state == ALIGN) && !mem_inc) begin
                align_seen <= 1'b1;
                if (align_seen && mem_full) begin
                    align_final <= 1'b1;
                end
            end
            sample_ack  <= (next_state == WRITE);
            mem_write   <= (next_state == WRITE);
            mem_read    <= (next_state == RD_REQ);
            mem_address <= (next_state == RD_REQ) ? rcnt_nxt : '0;
            rd_valid    <= (next_state == OUT);
            if (state == RD_WAIT) begin
                rd_data <= mem_data_out;
            end
            busy <= (next_state != IDLE);
            done <= (state == OUT) && rd_ready && (rcnt == LAST);
        end
    end

endmodule
